// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Build option: PLL_SUPERVISOR_AUTO_RELOCK_EN selects automatic re-reset instead of fault latching.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int RELOCK_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// N-flop single-bit synchronizer for the asynchronous PLL locked indication.
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic refclk,
  input  logic rst,
  input  logic d_async,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_async};
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, qualifies lock and holds downstream reset until lock is stable.
// Build option: PLL_SUPERVISOR_AUTO_RELOCK_EN re-pulses the PLL on timeout/loss instead of latching a fault.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int RESET_HOLD_CYCLES   = 256,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 7425000
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                locked_async,
  output logic                pll_rst,
  output logic                sys_rst,
  output logic                ready,
  output logic                fault,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam int CNT_MAX = max3(RESET_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic       locked_sync;
  pll_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       pll_rst_q, pll_rst_d;
  logic       sys_rst_q, sys_rst_d;
  logic       ready_q, ready_d;

  pll_lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .refclk  (refclk),
    .rst     (rst),
    .d_async (locked_async),
    .q       (locked_sync)
  );

`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
  logic                relock_event;
  logic [RELOCK_W-1:0] relock_q, relock_d;
`else
  logic                fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
    relock_event = 1'b0;
`endif
    case (state_q)
      RESET: begin
        if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout edge wins over the timeout.
        if (locked_sync) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
          state_d      = RESET;
          relock_event = 1'b1;
`else
          state_d = FAULT;
`endif
        end
      end
      STABLE: begin
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!locked_sync) begin
`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
          state_d      = RESET;
          relock_event = 1'b1;
`else
          state_d = FAULT;
`endif
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET;
      end
    endcase

    cnt_d = (state_d != state_q) ? '0 : CNT_W'(cnt_q + 1'b1);

    // Outputs decode the next state so they change on the same edge as the state register.
    pll_rst_d = (state_d == RESET);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
    relock_d = relock_q;
    if (relock_event && (relock_q != '1)) relock_d = relock_q + 1'b1;
`else
    fault_d = (state_d == FAULT);
`endif
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign fault        = 1'b0;
  assign relock_count = relock_q;
`else
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault        = fault_q;
  assign relock_count = '0;
`endif

  assign pll_rst = pll_rst_q;
  assign sys_rst = sys_rst_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short cycle parameters (sync 2, hold 4, stable 8, timeout 32).
// Works in both builds; PLL_SUPERVISOR_AUTO_RELOCK_EN selects the relock expectations.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_async = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES         (2),
    .RESET_HOLD_CYCLES   (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked_async (locked_async),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fault        (fault),
    .relock_count (relock_count)
  );

  always #5 refclk = ~refclk;

  // {locked_async driven before the edge, expected {pll_rst, sys_rst, ready, fault} after it}
  typedef struct packed {
    logic       locked;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [3:0] outs();
    return {pll_rst, sys_rst, ready, fault};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step(input logic l);
    locked_async = l;
    @(posedge refclk);
    #1;
  endtask

  // Steps with the current locked_async until output bit 'which' (0 pll_rst, 1 sys_rst,
  // 2 ready, 3 fault) equals val; n is the number of edges taken, -1 if the budget ran out.
  task automatic count_until(input int which, input logic val, input int budget, output int n);
    logic [3:0] o;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step(locked_async);
      o = outs();
      if (o[3-which] == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset(input string name);
    #2;
    rst = 1'b1;
    locked_async = 1'b0;
    #1;
    check({name, " reset outs"}, outs(), 4'b1100);
    check({name, " reset relock"}, relock_count, 8'd0);
    repeat (2) @(posedge refclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Scenario 1 timeline: edge k after reset release; lock raised two edges after pll_rst falls.
    tbl[0]  = {1'b0, 4'b1100};
    tbl[1]  = {1'b0, 4'b1100};
    tbl[2]  = {1'b0, 4'b1100};
    tbl[3]  = {1'b0, 4'b0100};
    tbl[4]  = {1'b0, 4'b0100};
    tbl[5]  = {1'b0, 4'b0100};
    tbl[6]  = {1'b1, 4'b0100};
    tbl[7]  = {1'b1, 4'b0100};
    tbl[8]  = {1'b1, 4'b0100};
    tbl[9]  = {1'b1, 4'b0100};
    tbl[10] = {1'b1, 4'b0100};
    tbl[11] = {1'b1, 4'b0100};
    tbl[12] = {1'b1, 4'b0100};
    tbl[13] = {1'b1, 4'b0100};
    tbl[14] = {1'b1, 4'b0100};
    tbl[15] = {1'b1, 4'b0100};
    tbl[16] = {1'b1, 4'b0010};
    tbl[17] = {1'b1, 4'b0010};

    // Reset values, held with clocks running.
    #12;
    check("s0 reset outs", outs(), 4'b1100);
    check("s0 reset relock", relock_count, 8'd0);
    @(posedge refclk);
    #1;
    rst = 1'b0;

    // 1: basic bring-up; lock sampled at edge 7, release at edge 17.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].locked);
      check($sformatf("s1 edge %0d", i + 1), outs(), tbl[i].exp);
    end
    check("s1 relock", relock_count, 8'd0);

    // 4: two-cycle lock drop in RUN; reaction on the third edge after the drop.
    step(1'b0);
    check("s4 drop edge1", outs(), 4'b0010);
    step(1'b0);
    check("s4 drop edge2", outs(), 4'b0010);
    step(1'b1);
`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
    check("s4 loss outs", outs(), 4'b1100);
    check("s4 relock", relock_count, 8'd1);
    count_until(0, 1'b0, 20, n);
    check("s4 pll_rst width", n, 4);
    // WAIT_LOCK on the falling edge of pll_rst, STABLE one edge later, RUN 8 after that.
    count_until(1, 1'b0, 40, n);
    check("s4 re-release", n, 9);
    check("s4 ready", ready, 1'b1);
`else
    check("s4 loss outs", outs(), 4'b0101);
    check("s4 relock", relock_count, 8'd0);
    repeat (5) step(1'b1);
    check("s4 fault sticky", outs(), 4'b0101);
`endif

    // 2: short lock glitch must not release sys_rst.
    do_reset("s2");
    count_until(0, 1'b0, 20, n);
    check("s2 pll_rst width", n, 4);
    for (int i = 0; i < 8; i++) begin
      step((i < 5) ? 1'b1 : 1'b0);
      check($sformatf("s2 glitch edge %0d sys_rst", i + 1), sys_rst, 1'b1);
    end
    step(1'b1);
    check("s2 final rise sys_rst", sys_rst, 1'b1);
    count_until(1, 1'b0, 40, n);
    check("s2 release latency", n, 10);
    check("s2 relock", relock_count, 8'd0);

    // 3: lock never arrives.
    do_reset("s3");
    count_until(0, 1'b0, 20, n);
    check("s3 pll_rst width", n, 4);
`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
    count_until(0, 1'b1, 64, n);
    check("s3 timeout1", n, 32);
    check("s3 relock1", relock_count, 8'd1);
    count_until(0, 1'b0, 20, n);
    check("s3 repulse width", n, 4);
    count_until(0, 1'b1, 64, n);
    check("s3 timeout2", n, 32);
    check("s3 relock2", relock_count, 8'd2);
`else
    count_until(3, 1'b1, 64, n);
    check("s3 timeout", n, 32);
    check("s3 fault outs", outs(), 4'b0101);
    check("s3 relock", relock_count, 8'd0);
`endif

    // 5: relock counter saturation.
`ifdef PLL_SUPERVISOR_AUTO_RELOCK_EN
    do_reset("s5");
    for (int k = 0; k < 260; k++) begin
      locked_async = 1'b1;
      count_until(2, 1'b1, 64, n);
      if (n != 13) check($sformatf("s5 lock %0d", k), n, 13);
      locked_async = 1'b0;
      count_until(1, 1'b1, 10, n);
      if (n != 3) check($sformatf("s5 loss %0d", k), n, 3);
      if (k == 99) check("s5 relock at 100", relock_count, 8'd100);
    end
    check("s5 relock saturated", relock_count, 8'd255);
    check("s5 outs", outs(), 4'b1100);
`else
    do_reset("s6 pre");
`endif

    // 6: asynchronous reset in the middle of STABLE, then a clean re-run.
    locked_async = 1'b1;
    count_until(0, 1'b0, 20, n);
    check("s6 pll_rst width", n, 4);
    step(1'b1);
    step(1'b1);
    check("s6 in STABLE", outs(), 4'b0100);
    #3;
    rst = 1'b1;
    #1;
    check("s6 async outs", outs(), 4'b1100);
    check("s6 async relock", relock_count, 8'd0);
    @(posedge refclk);
    #1;
    check("s6 held outs", outs(), 4'b1100);
    rst = 1'b0;
    count_until(0, 1'b0, 20, n);
    check("s6 rerun pll_rst width", n, 4);
    count_until(1, 1'b0, 40, n);
    check("s6 rerun release", n, 9);
    check("s6 rerun ready", outs(), 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
